// File: rtl/vga_plotter.sv
// rtl/vga_plotter.sv - pixel/filled-rectangle drawing engine feeding the VGA adapter write port
module vga_plotter #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 3,
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t        state_q;
    logic [XW-1:0] x0_q, w_q, cx_q, x_q;
    logic [YW-1:0] y0_q, h_q, cy_q, y_q;
    logic [CW-1:0] colour_q;
    logic          plot_q, done_q;

    logic [XW-1:0] acc_w, nx;
    logic [YW-1:0] acc_h, ny;
    logic          row_end, last;
    logic [XW:0]   sx_d;
    logic [YW:0]   sy_d;
    logic          in_range;

    // cx/cy index the pixel currently on the outputs; nx/ny is the one registered next.
    always_comb begin
        acc_w    = cmd_op ? cmd_w : XW'(1);
        acc_h    = cmd_op ? cmd_h : YW'(1);
        row_end  = (cx_q == w_q - XW'(1));
        last     = row_end && (cy_q == h_q - YW'(1));
        nx       = row_end ? '0 : cx_q + XW'(1);
        ny       = row_end ? cy_q + YW'(1) : cy_q;
        sx_d     = {1'b0, cmd_x0};
        sy_d     = {1'b0, cmd_y0};
        if (state_q == DRAW) begin
            sx_d = {1'b0, x0_q} + {1'b0, nx};
            sy_d = {1'b0, y0_q} + {1'b0, ny};
        end
        // Carry-out of the widened sums lands beyond the screen, so it never wraps back on.
        in_range = (sx_d < (XW+1)'(XMAX)) && (sy_d < (YW+1)'(YMAX));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        x0_q     <= cmd_x0;
                        y0_q     <= cmd_y0;
                        w_q      <= acc_w;
                        h_q      <= acc_h;
                        colour_q <= cmd_colour;
                        cx_q     <= '0;
                        cy_q     <= '0;
                        if (acc_w == '0 || acc_h == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= DRAW;
                            x_q     <= sx_d[XW-1:0];
                            y_q     <= sy_d[YW-1:0];
                            plot_q  <= in_range;
                        end
                    end
                end
                DRAW: begin
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cx_q   <= nx;
                        cy_q   <= ny;
                        x_q    <= sx_d[XW-1:0];
                        y_q    <= sy_d[YW-1:0];
                        plot_q <= in_range;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == DRAW);
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_plotter.sv
// tb/tb_vga_plotter.sv - self-checking bench for vga_plotter
module tb_vga_plotter;

    localparam int XW = 8, YW = 7, CW = 3, XMAX = 160, YMAX = 120;
    localparam int PW = 1 + XW + YW + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [XW-1:0] cmd_x0 = '0;
    logic [YW-1:0] cmd_y0 = '0;
    logic [XW-1:0] cmd_w = '0;
    logic [YW-1:0] cmd_h = '0;
    logic [CW-1:0] cmd_colour = '0;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot, busy, done;

    vga_plotter #(.XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_colour(cmd_colour), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit op;
        int x0, y0, w, h, col;
        int exp_plots, exp_cycles;
    } vec_t;

    vec_t             tbl[10];
    logic [PW-1:0]    sb[$];
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int px, input int py, input int col);
        bit on;
        on = (px < XMAX) && (py < YMAX);
        return {on, XW'(px), YW'(py), CW'(col)};
    endfunction

    task automatic push_model(input vec_t v);
        int ew, eh;
        ew = v.op ? v.w : 1;
        eh = v.op ? v.h : 1;
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                sb.push_back(pix(v.x0 + c, v.y0 + r, v.col));
    endtask

    task automatic drive(input vec_t v);
        cmd_valid  = 1'b1;
        cmd_op     = v.op;
        cmd_x0     = XW'(v.x0);
        cmd_y0     = YW'(v.y0);
        cmd_w      = XW'(v.w);
        cmd_h      = YW'(v.h);
        cmd_colour = CW'(v.col);
    endtask

    task automatic check_pixel();
        logic [PW-1:0] exp_p;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
        end else begin
            exp_p = sb.pop_front();
            chk("pixel{plot,x,y,colour}", {plot, x, y, colour}, exp_p);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, plots, draw, got_done;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        drive(v);
        push_model(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0; plots = 0; draw = 0; got_done = 0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (plot && !busy) chk("plot_without_busy", plot, 0);
            if (busy) begin
                draw++;
                if (plot) plots++;
                check_pixel();
            end
            if (done) got_done = 1;
        end
        chk("done_seen", got_done, 1);
        chk("draw_cycles", draw, v.exp_cycles);
        chk("plot_count", plots, v.exp_plots);
        chk("done_latency", cyc, v.exp_cycles + 1);
        chk("ready_with_done", cmd_ready, 1);
        chk("scoreboard_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        vec_t v;
        int seen_done, seen_busy;

        tbl[0] = '{0,   5,   7,  9, 9, 5,  1,  1};
        tbl[1] = '{1,  10,  20,  3, 2, 2,  6,  6};
        tbl[2] = '{1, 158, 118,  4, 4, 7,  4, 16};
        tbl[3] = '{1, 250,   0, 10, 1, 1,  0, 10};
        tbl[4] = '{1,  30,  40,  0, 5, 3,  0,  0};
        tbl[5] = '{1,  30,  40,  3, 0, 3,  0,  0};
        tbl[6] = '{1,   0,   0,  1, 1, 4,  1,  1};
        tbl[7] = '{1, 159, 119,  2, 1, 6,  1,  2};
        tbl[8] = '{1,   3, 118,  1, 4, 6,  2,  4};
        tbl[9] = '{1,  60, 126,  2, 4, 2,  0,  8};

        repeat (2) @(negedge clk);
        chk("rst_outputs{x,y,colour,plot,busy,done}", {x, y, colour, plot, busy, done}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Zero-area command, then a pixel accepted on the done cycle.
        @(negedge clk);
        v = '{1, 1, 1, 0, 5, 3, 0, 0};
        drive(v);
        @(negedge clk);
        chk("zero_area_done", done, 1);
        chk("zero_area_ready", cmd_ready, 1);
        chk("zero_area_no_busy", {busy, plot}, 0);
        v = '{0, 40, 50, 0, 0, 4, 1, 1};
        drive(v);
        push_model(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        check_pixel();
        @(negedge clk);
        chk("b2b_done", done, 1);

        // Reset while the third pixel of a 4x4 rectangle is on the outputs.
        @(negedge clk);
        v = '{1, 20, 30, 4, 4, 6, 16, 16};
        drive(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_reset_pixel3{plot,x,y}", {plot, x, y}, {1'b1, 8'd22, 7'd30});
        #1 reset = 1'b0;
        #1 chk("reset_now{x,y,colour,plot,busy,done}", {x, y, colour, plot, busy, done}, 0);
        chk("reset_now_ready", cmd_ready, 1);
        seen_done = 0; seen_busy = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1;
            if (busy || plot) seen_busy = 1;
        end
        chk("aborted_no_done", seen_done, 0);
        chk("aborted_stays_idle", seen_busy, 0);
        chk("post_reset_ready", cmd_ready, 1);
        v = '{0, 100, 60, 0, 0, 3, 1, 1};
        run_vec(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
